// File: rtl/filt_pkg.sv
// Shared defaults, controller state encoding and in-flight tag layout for the FIR controller.
package filt_pkg;

  localparam int unsigned NTAPS_DEF    = 15;
  localparam int unsigned DW_DEF       = 20;
  localparam int unsigned YW_DEF       = 40;
  localparam int unsigned FILT_LAT_DEF = 3;

  typedef enum logic [1:0] {
    StRun,
    StSwap,
    StFlush
  } state_e;

  typedef struct packed {
    logic valid;
    logic is_flush;
  } tag_t;

endpackage

// File: rtl/filt_ctrl_if.sv
// Source, configuration, datapath and sink signals of filt_ctrl.
// The slave modport is the controller side; master is the surrounding environment.
interface filt_ctrl_if import filt_pkg::*; #(
  parameter int unsigned NTAPS = NTAPS_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned YW    = YW_DEF
);
  logic                   s_pushin;
  logic signed [DW-1:0]   s_x;
  logic                   s_stop;
  logic                   cfg_we;
  logic [3:0]             cfg_addr;
  logic signed [DW-1:0]   cfg_data;
  logic                   cfg_commit;
  logic                   cfg_busy;
  logic                   f_pushin;
  logic signed [DW-1:0]   f_x;
  logic [NTAPS*DW-1:0]    f_coef;
  logic                   f_pushout;
  logic signed [YW-1:0]   f_y;
  logic                   m_pushout;
  logic signed [YW-1:0]   m_y;
  logic                   err;

  modport slave (
    input  s_pushin, s_x, cfg_we, cfg_addr, cfg_data, cfg_commit, f_pushout, f_y,
    output s_stop, cfg_busy, f_pushin, f_x, f_coef, m_pushout, m_y, err
  );

  modport master (
    output s_pushin, s_x, cfg_we, cfg_addr, cfg_data, cfg_commit, f_pushout, f_y,
    input  s_stop, cfg_busy, f_pushin, f_x, f_coef, m_pushout, m_y, err
  );
endinterface

// File: rtl/filt_tag_sr.sv
// Shift register of {valid, is_flush} tags, one stage per datapath latency cycle.
module filt_tag_sr import filt_pkg::*; #(
  parameter int unsigned FILT_LAT = FILT_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_i,
  output tag_t head_o
);

  tag_t sr_q [FILT_LAT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FILT_LAT; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= tag_i;
      for (int i = 1; i < FILT_LAT; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign head_o = sr_q[FILT_LAT-1];

endmodule

// File: rtl/filt_ctrl.sv
// FIR datapath controller: shadow/active coefficient banks, commit swap and result gating.
// Define FILT_CTRL_FLUSH_EN to push NTAPS zero samples after each swap.
module filt_ctrl import filt_pkg::*; #(
  parameter int unsigned NTAPS    = NTAPS_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned YW       = YW_DEF,
  parameter int unsigned FILT_LAT = FILT_LAT_DEF
) (
  input logic        clk,
  input logic        reset,
  filt_ctrl_if.slave bus
);

  localparam int unsigned CW = ($clog2(NTAPS) > 0) ? $clog2(NTAPS) : 1;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [DW-1:0] shadow_q [NTAPS];
  logic signed [DW-1:0] active_q [NTAPS];
  logic                 f_pushin_q, f_pushin_d;
  logic signed [DW-1:0] f_x_q, f_x_d;
  logic                 flush_q, flush_d;
  logic                 m_pushout_q, m_pushout_d;
  logic signed [YW-1:0] m_y_q;
  logic                 err_q, err_d;
  logic                 stop;
  logic                 swap_en;
  tag_t                 head;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    f_pushin_d = 1'b0;
    f_x_d      = '0;
    flush_d    = 1'b0;
    swap_en    = 1'b0;
    stop       = 1'b1;
    unique case (state_q)
      StRun: begin
        // Stall already in the commit cycle so no sample slips past the swap.
        stop       = bus.cfg_commit;
        f_pushin_d = bus.s_pushin & ~bus.cfg_commit;
        f_x_d      = bus.s_x;
        if (bus.cfg_commit) state_d = StSwap;
      end
      StSwap: begin
        swap_en = 1'b1;
`ifdef FILT_CTRL_FLUSH_EN
        state_d = StFlush;
        cnt_d   = CW'(NTAPS - 1);
`else
        state_d = StRun;
`endif
      end
      StFlush: begin
        f_pushin_d = 1'b1;
        flush_d    = 1'b1;
        if (cnt_q == '0) state_d = StRun;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = StRun;
    endcase

    m_pushout_d = bus.f_pushout & head.valid & ~head.is_flush;
    err_d       = err_q | (bus.s_pushin & stop) | (bus.f_pushout ^ head.valid);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      f_pushin_q  <= 1'b0;
      f_x_q       <= '0;
      flush_q     <= 1'b0;
      m_pushout_q <= 1'b0;
      m_y_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      f_pushin_q  <= f_pushin_d;
      f_x_q       <= f_x_d;
      flush_q     <= flush_d;
      m_pushout_q <= m_pushout_d;
      if (m_pushout_d) m_y_q <= bus.f_y;
      err_q       <= err_d;
    end
  end

  // A write in the commit cycle lands in shadow before SWAP copies it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      if (bus.cfg_we && (32'(bus.cfg_addr) < NTAPS)) shadow_q[bus.cfg_addr] <= bus.cfg_data;
      if (swap_en) active_q <= shadow_q;
    end
  end

  filt_tag_sr #(
    .FILT_LAT (FILT_LAT)
  ) u_tag_sr (
    .clk    (clk),
    .reset  (reset),
    .tag_i  ('{valid: f_pushin_q, is_flush: flush_q}),
    .head_o (head)
  );

  for (genvar k = 0; k < NTAPS; k++) begin : g_coef
    assign bus.f_coef[DW*k +: DW] = active_q[k];
  end

  assign bus.s_stop    = reset & stop;
  assign bus.cfg_busy  = reset & stop;
  assign bus.f_pushin  = f_pushin_q;
  assign bus.f_x       = f_x_q;
  assign bus.m_pushout = m_pushout_q;
  assign bus.m_y       = m_y_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_filt_ctrl.sv
// Bench for filt_ctrl: behavioural FIR datapath plus a coefficient/history reference model.
module tb_filt_ctrl;
  import filt_pkg::*;

  localparam int unsigned NTAPS = NTAPS_DEF;
  localparam int unsigned DW    = DW_DEF;
  localparam int unsigned YW    = YW_DEF;
  localparam int unsigned LAT   = FILT_LAT_DEF;
`ifdef FILT_CTRL_FLUSH_EN
  localparam bit FLUSH = 1'b1;
  localparam int BUSY  = 2 + NTAPS;
`else
  localparam bit FLUSH = 1'b0;
  localparam int BUSY  = 2;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  filt_ctrl_if #(.NTAPS(NTAPS), .DW(DW), .YW(YW)) bus ();

  filt_ctrl #(
    .NTAPS    (NTAPS),
    .DW       (DW),
    .YW       (YW),
    .FILT_LAT (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural FIR datapath: uses the active bank on f_coef, answers LAT cycles later.
  logic signed [DW-1:0] dp_hist [NTAPS];
  logic                 dp_v [LAT];
  logic signed [YW-1:0] dp_y [LAT];
  logic                 stray;

  assign bus.f_pushout = dp_v[LAT-1] | stray;
  assign bus.f_y       = dp_y[LAT-1];

  function automatic logic signed [YW-1:0] dp_fir(input logic signed [DW-1:0] x);
    longint acc;
    acc = longint'($signed(bus.f_coef[DW-1:0])) * longint'(x);
    for (int k = 1; k < NTAPS; k++)
      acc += longint'($signed(bus.f_coef[DW*k +: DW])) * longint'(dp_hist[k-1]);
    return YW'(acc);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NTAPS; k++) dp_hist[k] <= '0;
      for (int i = 0; i < LAT; i++) begin
        dp_v[i] <= 1'b0;
        dp_y[i] <= '0;
      end
    end else begin
      if (bus.f_pushin) begin
        dp_hist[0] <= bus.f_x;
        for (int k = 1; k < NTAPS; k++) dp_hist[k] <= dp_hist[k-1];
      end
      dp_v[0] <= bus.f_pushin;
      dp_y[0] <= bus.f_pushin ? dp_fir(bus.f_x) : '0;
      for (int i = 1; i < LAT; i++) begin
        dp_v[i] <= dp_v[i-1];
        dp_y[i] <= dp_y[i-1];
      end
    end
  end

  // Reference model: what the sink should see, derived from the bench's own writes and pushes.
  typedef struct {
    int                   due;
    logic signed [YW-1:0] y;
  } exp_t;

  longint ref_sh  [NTAPS];
  longint ref_act [NTAPS];
  longint ref_hist[$];
  exp_t   exp_q[$];
  bit     ref_err;
  int     busy_left;
  int     cyc;
  int     fp_cnt;
  int     busy_cnt;
  int     n_cmp;
  int     n_bad;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic ref_clear();
    for (int k = 0; k < NTAPS; k++) begin
      ref_sh[k]  = 0;
      ref_act[k] = 0;
    end
    ref_hist.delete();
    for (int k = 0; k < NTAPS; k++) ref_hist.push_back(0);
    exp_q.delete();
    ref_err   = 1'b0;
    busy_left = 0;
  endtask

  task automatic ref_accept(input longint x);
    longint y;
    exp_t   e;
    ref_hist.push_front(x);
    void'(ref_hist.pop_back());
    y = 0;
    for (int k = 0; k < NTAPS; k++) y += ref_act[k] * ref_hist[k];
    e.due = cyc + LAT + 2;
    e.y   = YW'(y);
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    logic exp_stop;
    logic mo_exp;
    #1;
    exp_stop = (busy_left > 0) || bus.cfg_commit;
    chk("s_stop", 64'(bus.s_stop), 64'(exp_stop));
    chk("cfg_busy", 64'(bus.cfg_busy), 64'(exp_stop));
    if (bus.cfg_we && (32'(bus.cfg_addr) < NTAPS)) ref_sh[bus.cfg_addr] = longint'(bus.cfg_data);
    if (bus.s_pushin) begin
      if (exp_stop) ref_err = 1'b1;
      else          ref_accept(longint'(bus.s_x));
    end
    if (stray) ref_err = 1'b1;
    if (busy_left > 0) begin
      busy_left--;
    end else if (bus.cfg_commit) begin
      busy_left = BUSY - 1;
      ref_act   = ref_sh;
      if (FLUSH) for (int k = 0; k < NTAPS; k++) begin
        ref_hist.push_front(0);
        void'(ref_hist.pop_back());
      end
    end
    if (bus.f_pushin) fp_cnt++;
    if (bus.s_stop) busy_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    mo_exp = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    chk("m_pushout", 64'(bus.m_pushout), 64'(mo_exp));
    if (mo_exp) begin
      chk("m_y", 64'(bus.m_y), 64'(exp_q[0].y));
      void'(exp_q.pop_front());
    end
    chk("err", 64'(bus.err), 64'(ref_err));
  endtask

  task automatic clear_inputs();
    bus.s_pushin   = 1'b0;
    bus.s_x        = '0;
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_data   = '0;
    bus.cfg_commit = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push(input int x);
    bus.s_pushin = 1'b1;
    bus.s_x      = DW'(x);
    cycle();
    bus.s_pushin = 1'b0;
  endtask

  task automatic cfg(input int addr, input int data, input bit commit);
    bus.cfg_we     = 1'b1;
    bus.cfg_addr   = 4'(addr);
    bus.cfg_data   = DW'(data);
    bus.cfg_commit = commit;
    cycle();
    clear_inputs();
  endtask

  task automatic commit_only();
    bus.cfg_commit = 1'b1;
    cycle();
    bus.cfg_commit = 1'b0;
  endtask

  task automatic check_coef();
    for (int k = 0; k < NTAPS; k++)
      chk("f_coef", 64'($signed(bus.f_coef[DW*k +: DW])), 64'(ref_act[k]));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_f_pushin"}, 64'(bus.f_pushin), 64'(0));
    chk({tag, "_f_x"}, 64'(bus.f_x), 64'(0));
    chk({tag, "_m_pushout"}, 64'(bus.m_pushout), 64'(0));
    chk({tag, "_m_y"}, 64'(bus.m_y), 64'(0));
    chk({tag, "_err"}, 64'(bus.err), 64'(0));
    chk({tag, "_s_stop"}, 64'(bus.s_stop), 64'(0));
    chk({tag, "_cfg_busy"}, 64'(bus.cfg_busy), 64'(0));
    chk({tag, "_f_coef"}, 64'(bus.f_coef == '0), 64'(1));
  endtask

  initial begin
    int snap_fp;
    int snap_busy;
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    fp_cnt = 0;
    busy_cnt = 0;
    stray = 1'b0;
    clear_inputs();
    ref_clear();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;

    // Zero coefficients: every sample of 1 yields 0.
    for (int i = 0; i < 20; i++) push(1);
    idle(LAT + 4);

    // Tap 0 = 1, then commit; count busy cycles and datapath pushes across the swap.
    cfg(0, 1, 1'b0);
    snap_fp   = fp_cnt;
    snap_busy = busy_cnt;
    commit_only();
    idle(BUSY + 2);
    chk("busy_cycles", 64'(busy_cnt - snap_busy), 64'(BUSY));
    chk("flush_pushes", 64'(fp_cnt - snap_fp), FLUSH ? 64'(NTAPS) : 64'(0));
    push(5);
    idle(LAT + 3);

    // Write landing in the commit cycle must be part of the swapped bank.
    cfg(3, 7, 1'b1);
    idle(BUSY + 2);
    chk("tap3", 64'($signed(bus.f_coef[DW*3 +: DW])), 64'(7));
    check_coef();

    // Random writes (including out-of-range addresses), commits and pushes.
    for (int i = 0; i < 300; i++) begin
      bus.cfg_we     = ($urandom_range(3) == 0);
      bus.cfg_addr   = 4'($urandom_range(15));
      bus.cfg_data   = DW'(int'($urandom_range(1000)) - 500);
      bus.cfg_commit = ($urandom_range(39) == 0);
      bus.s_pushin   = (busy_left == 0) && !bus.cfg_commit && ($urandom_range(1) == 1);
      bus.s_x        = DW'(int'($urandom_range(1000)) - 500);
      cycle();
    end
    clear_inputs();
    idle(BUSY + LAT + 4);
    check_coef();

    // Push while stalled: dropped and err becomes sticky.
    commit_only();
    push(9);
    idle(BUSY + LAT + 3);
    push(3);
    idle(LAT + 3);

    // Reset in the middle of the swap/flush window.
    commit_only();
    idle(FLUSH ? 4 : 0);
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    ref_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(LAT + 6);

    // Stray datapath result with nothing in flight.
    stray = 1'b1;
    cycle();
    stray = 1'b0;
    idle(3);
    push(2);
    idle(LAT + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
